press_classifier: RTL and testbench
===================================

PRESS_CLASSIFIER -- requirements
Module: press_classifier

Interface
REQ-001 SHALL have parameter N, default 32, timer bitwidth.
REQ-002 SHALL have parameter FREQ, default 50, clock frequency in MHz.
REQ-003 SHALL have parameter LONG_MS, default 600, hold time for a long press.
REQ-004 SHALL have parameter DOUBLE_MS, default 250, max release-to-second-press gap for a double click.
REQ-005 SHALL have parameter REPEAT_MS, default 100, auto-repeat period while long-held.
REQ-006 SHALL have port clk, input, 1, clock.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port btn_negedge, input, 1, one-cycle strobe from the debouncer; press (button is active-low).
REQ-009 SHALL have port btn_posedge, input, 1, one-cycle strobe from the debouncer; release.
REQ-010 SHALL have port short_press, output, 1, one-cycle pulse.
REQ-011 SHALL have port long_press, output, 1, one-cycle pulse.
REQ-012 SHALL have port double_click, output, 1, one-cycle pulse.
REQ-013 SHALL have port repeat_tick, output, 1, one-cycle pulse.
REQ-014 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-015 SHALL compute ticks as MS*1000*FREQ for LONG, DOUBLE and REPEAT; all counting in N-bit unsigned, no wrap (timer saturates at its terminal value).
REQ-016 SHALL implement states IDLE, PRESSED, LONG_HELD, WAIT_SECOND, SECOND_PRESSED; timer cleared on every state entry.
REQ-017 IDLE: press -> PRESSED; release ignored.
REQ-018 PRESSED: release while timer < LONG_TICKS -> WAIT_SECOND; timer == LONG_TICKS with no release -> LONG_HELD and long_press pulse.
REQ-019 LONG_HELD: release -> IDLE with no short_press.
REQ-020 WAIT_SECOND: press while timer < DOUBLE_TICKS -> SECOND_PRESSED and double_click pulse; timer == DOUBLE_TICKS -> IDLE and short_press pulse.
REQ-021 SECOND_PRESSED: release -> IDLE; no long_press regardless of hold duration.
REQ-022 All outputs SHALL be registered; each pulse asserts for exactly one clk, on the edge that performs the transition.
REQ-023 Press and release strobes both high in the same cycle SHALL be ignored (state and timer unchanged apart from normal counting).
REQ-024 A release and the terminal timer value in the same cycle in PRESSED SHALL resolve as the release (-> WAIT_SECOND, no long_press); in WAIT_SECOND a press at terminal count SHALL resolve as the press (double_click).
REQ-025 At most one of short_press, long_press, double_click SHALL be high in any cycle.

Reset
REQ-026 On rst, state SHALL be IDLE, timer 0, and all outputs (short_press, long_press, double_click, repeat_tick, busy) SHALL be 0.
REQ-027 Reset asserted mid-gesture SHALL discard the gesture; no pulse emitted after reset release until a new press.

Configuration
REQ-028 Macro PRESS_CLASSIFIER_REPEAT_EN defined: in LONG_HELD, repeat_tick SHALL pulse every REPEAT_TICKS cycles, first pulse REPEAT_TICKS cycles after the long_press pulse, stopping on release.
REQ-029 Macro PRESS_CLASSIFIER_REPEAT_EN undefined: repeat_tick SHALL be tied to 0 and no repeat counter logic SHALL be synthesised.

Structure
REQ-030 Package press_classifier_pkg SHALL hold the state encodings and the ms-to-ticks constant function.
REQ-031 A sub-module press_timer SHALL implement the clearable, saturating N-bit counter with a terminal-count compare output; it is instantiated once (twice with REPEAT_EN).

Verification (FREQ=1, LONG_MS=2, DOUBLE_MS=1, REPEAT_MS=1: ticks 2000/1000/1000)
REQ-032 Press, release after 500 cycles, no further press -> single short_press exactly 1000 cycles after release; busy low thereafter.
REQ-033 Press, release after 300, press again 400 cycles later -> double_click on that press edge; no short_press; release -> IDLE.
REQ-034 Press held 5000 cycles -> long_press at cycle 2000; with REPEAT_EN repeat_tick at 3000 and 4000; without it repeat_tick stays 0; release yields no short_press.
REQ-035 Release coincident with timer == 2000 in PRESSED -> no long_press; short_press 1000 cycles later.
REQ-036 rst pulsed 100 cycles into PRESSED -> all outputs 0 during and after reset; a later release alone produces no pulse.
REQ-037 Press and release strobes both asserted in one cycle from IDLE -> state stays IDLE, no pulses, busy stays 0.

Source files
------------

// File: rtl/press_classifier_pkg.sv
// Shared state encoding and the ms-to-ticks constant function for press_classifier.
package press_classifier_pkg;

  typedef enum logic [2:0] {
    ST_IDLE           = 3'd0,
    ST_PRESSED        = 3'd1,
    ST_LONG_HELD      = 3'd2,
    ST_WAIT_SECOND    = 3'd3,
    ST_SECOND_PRESSED = 3'd4
  } state_t;

  // Cycles in ms milliseconds at freq_mhz MHz; callers truncate to their timer width.
  function automatic logic [63:0] ms_to_ticks(input int unsigned ms, input int unsigned freq_mhz);
    return 64'(ms) * 64'd1000 * 64'(freq_mhz);
  endfunction

endpackage

// File: rtl/press_timer.sv
// Clearable N-bit up-counter that saturates at a terminal value and flags it.
module press_timer #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [N-1:0] terminal,
  output logic         done
);

  localparam logic [N-1:0] ONE = 1;

  logic [N-1:0] count;

  // NOTE: sequential state is written only with non-blocking assignments, so every
  // flop samples its inputs from before the edge regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count != terminal) begin
      count <= count + ONE;
    end
  end

  assign done = (count == terminal);

endmodule

// File: rtl/press_classifier.sv
// Classifies debounced button strobes into short / long / double-click gestures.
// Define PRESS_CLASSIFIER_REPEAT_EN to enable auto-repeat ticks while long-held.
module press_classifier
  import press_classifier_pkg::*;
#(
  parameter int N         = 32,
  parameter int FREQ      = 50,
  parameter int LONG_MS   = 600,
  parameter int DOUBLE_MS = 250,
  parameter int REPEAT_MS = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_negedge,
  input  logic btn_posedge,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic repeat_tick,
  output logic busy
);

  localparam logic [N-1:0] ONE          = 1;
  localparam logic [N-1:0] LONG_TICKS   = N'(ms_to_ticks(LONG_MS, FREQ));
  localparam logic [N-1:0] DOUBLE_TICKS = N'(ms_to_ticks(DOUBLE_MS, FREQ));
  // The counter reads 0 in the first cycle after entry, so comparing against
  // TICKS-1 makes the transition land exactly TICKS edges after entry.
  localparam logic [N-1:0] LONG_LAST    = LONG_TICKS - ONE;
  localparam logic [N-1:0] DOUBLE_LAST  = DOUBLE_TICKS - ONE;

  state_t       state;
  state_t       next_state;
  logic         press;
  logic         release_evt;
  logic         timer_clear;
  logic         timer_done;
  logic [N-1:0] timer_terminal;
  logic         short_nxt;
  logic         long_nxt;
  logic         double_nxt;

  // Coincident press and release strobes cancel out.
  assign press       = btn_negedge & ~btn_posedge;
  assign release_evt = btn_posedge & ~btn_negedge;

  assign timer_clear    = (next_state != state);
  assign timer_terminal = (state == ST_WAIT_SECOND) ? DOUBLE_LAST : LONG_LAST;

  press_timer #(.N(N)) u_main_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (timer_clear),
    .terminal (timer_terminal),
    .done     (timer_done)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves one
    // unassigned and no latch can be inferred.
    next_state = state;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    double_nxt = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (press) next_state = ST_PRESSED;
      end
      ST_PRESSED: begin
        // Release takes priority over reaching the long-press threshold.
        if (release_evt) begin
          next_state = ST_WAIT_SECOND;
        end else if (timer_done) begin
          next_state = ST_LONG_HELD;
          long_nxt   = 1'b1;
        end
      end
      ST_LONG_HELD: begin
        if (release_evt) next_state = ST_IDLE;
      end
      ST_WAIT_SECOND: begin
        // A second press on the terminal cycle still counts as a double click.
        if (press) begin
          next_state = ST_SECOND_PRESSED;
          double_nxt = 1'b1;
        end else if (timer_done) begin
          next_state = ST_IDLE;
          short_nxt  = 1'b1;
        end
      end
      ST_SECOND_PRESSED: begin
        if (release_evt) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // NOTE: the asynchronous reset returns every flop, including the timer, to a known
  // value so a gesture interrupted by reset leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= next_state;
      short_press  <= short_nxt;
      long_press   <= long_nxt;
      double_click <= double_nxt;
      busy         <= (next_state != ST_IDLE);
    end
  end

`ifdef PRESS_CLASSIFIER_REPEAT_EN
  localparam logic [N-1:0] REPEAT_TICKS = N'(ms_to_ticks(REPEAT_MS, FREQ));
  localparam logic [N-1:0] REPEAT_LAST  = REPEAT_TICKS - ONE;

  logic repeat_clear;
  logic repeat_done;
  logic repeat_nxt;

  // Held at zero outside LONG_HELD, so the first tick is one period after long_press.
  assign repeat_clear = (state != ST_LONG_HELD) | repeat_done;
  assign repeat_nxt   = (state == ST_LONG_HELD) & ~release_evt & repeat_done;

  press_timer #(.N(N)) u_repeat_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (repeat_clear),
    .terminal (REPEAT_LAST),
    .done     (repeat_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      repeat_tick <= 1'b0;
    end else begin
      repeat_tick <= repeat_nxt;
    end
  end
`else
  assign repeat_tick = 1'b0;
`endif

endmodule

// File: tb/tb_press_classifier.sv
// Self-checking bench for press_classifier: timestamp-based reference model,
// directed gesture scenarios with literal timing expectations, then random strobes.
module tb_press_classifier;

  localparam int LONG_T = 2000;
  localparam int DBL_T  = 1000;
  localparam int REP_T  = 1000;
`ifdef PRESS_CLASSIFIER_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_negedge = 1'b0;
  logic btn_posedge = 1'b0;
  logic short_press, long_press, double_click, repeat_tick, busy;

  always #5 clk = ~clk;

  press_classifier #(
    .N(32), .FREQ(1), .LONG_MS(2), .DOUBLE_MS(1), .REPEAT_MS(1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_negedge  (btn_negedge),
    .btn_posedge  (btn_posedge),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_click (double_click),
    .repeat_tick  (repeat_tick),
    .busy         (busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Gesture model: where the button is in its gesture and when that phase began.
  typedef enum {M_IDLE, M_DOWN1, M_HOLD_LONG, M_GAP, M_DOWN2} mphase_t;
  mphase_t ph = M_IDLE;
  int  cyc = 0;
  int  t0  = 0;
  bit  e_short, e_long, e_dbl, e_rep, e_busy;

  int n_short = 0, n_long = 0, n_dbl = 0;
  int last_short = 0, last_long = 0, last_dbl = 0;
  int rep_q[$];

  always @(posedge clk) begin
    bit p, r;
    int el;
    cyc++;
    e_short = 0; e_long = 0; e_dbl = 0; e_rep = 0;
    p  = btn_negedge && !btn_posedge;
    r  = btn_posedge && !btn_negedge;
    el = cyc - t0;
    if (rst) begin
      ph = M_IDLE;
    end else begin
      case (ph)
        M_IDLE:      if (p) begin ph = M_DOWN1; t0 = cyc; end
        M_DOWN1:     if (r) begin ph = M_GAP; t0 = cyc; end
                     else if (el == LONG_T) begin e_long = 1; ph = M_HOLD_LONG; t0 = cyc; end
        M_HOLD_LONG: if (r) ph = M_IDLE;
                     else if (REP_EN && (el % REP_T) == 0) e_rep = 1;
        M_GAP:       if (p) begin e_dbl = 1; ph = M_DOWN2; t0 = cyc; end
                     else if (el == DBL_T) begin e_short = 1; ph = M_IDLE; end
        M_DOWN2:     if (r) ph = M_IDLE;
        default:     ph = M_IDLE;
      endcase
    end
    e_busy = (ph != M_IDLE);
    #1;
    check("short_press", short_press, e_short);
    check("long_press", long_press, e_long);
    check("double_click", double_click, e_dbl);
    check("repeat_tick", repeat_tick, e_rep);
    check("busy", busy, e_busy);
    check("pulse_exclusive", (int'(short_press) + int'(long_press) + int'(double_click)) > 1, 0);
    if (short_press)  begin n_short++; last_short = cyc; end
    if (long_press)   begin n_long++;  last_long  = cyc; end
    if (double_click) begin n_dbl++;   last_dbl   = cyc; end
    if (repeat_tick)  rep_q.push_back(cyc);
  end

  // Drive a one-cycle strobe so it is sampled on edge number `target` (or the next one if past).
  task automatic strobe_at(input int target, input bit neg, input bit pos, output int edge_no);
    while (cyc + 1 < target) @(negedge clk);
    btn_negedge = neg;
    btn_posedge = pos;
    edge_no = cyc + 1;
    @(negedge clk);
    btn_negedge = 1'b0;
    btn_posedge = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    int p, r, p2, r2, s0, l0, d0, q0;
    int rnd;

    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_short", short_press, 0);
    check("reset_long", long_press, 0);
    check("reset_repeat", repeat_tick, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Short press: release after 500, short_press exactly 1000 edges after release.
    s0 = n_short; l0 = n_long;
    strobe_at(cyc + 1, 1, 0, p);
    strobe_at(p + 500, 0, 1, r);
    wait_until(r + 1100);
    check("t1_short_count", n_short - s0, 1);
    check("t1_short_delay", last_short - r, 1000);
    check("t1_no_long", n_long - l0, 0);
    check("t1_busy_after", busy, 0);

    // Double click: second press 400 after release.
    s0 = n_short; d0 = n_dbl;
    strobe_at(cyc + 5, 1, 0, p);
    strobe_at(p + 300, 0, 1, r);
    strobe_at(r + 400, 1, 0, p2);
    wait_until(p2 + 3);
    check("t2_dbl_count", n_dbl - d0, 1);
    check("t2_dbl_edge", last_dbl - p2, 0);
    strobe_at(p2 + 50, 0, 1, r2);
    wait_until(r2 + 1100);
    check("t2_no_short", n_short - s0, 0);
    check("t2_busy_after", busy, 0);

    // Long hold of 5000 cycles.
    s0 = n_short; l0 = n_long; q0 = rep_q.size();
    strobe_at(cyc + 5, 1, 0, p);
    strobe_at(p + 5000, 0, 1, r);
    wait_until(r + 1200);
    check("t3_long_count", n_long - l0, 1);
    check("t3_long_delay", last_long - p, 2000);
    check("t3_repeat_count", rep_q.size() - q0, REP_EN ? 2 : 0);
`ifdef PRESS_CLASSIFIER_REPEAT_EN
    if (rep_q.size() - q0 >= 2) begin
      check("t3_repeat_first", rep_q[q0] - p, 3000);
      check("t3_repeat_second", rep_q[q0 + 1] - p, 4000);
    end
`endif
    check("t3_no_short", n_short - s0, 0);
    check("t3_busy_after", busy, 0);

    // Release exactly at the long threshold resolves as a release.
    s0 = n_short; l0 = n_long;
    strobe_at(cyc + 5, 1, 0, p);
    strobe_at(p + 2000, 0, 1, r);
    wait_until(r + 1100);
    check("t4_no_long", n_long - l0, 0);
    check("t4_short_count", n_short - s0, 1);
    check("t4_short_delay", last_short - r, 1000);

    // Reset mid-gesture discards it; the later release alone does nothing.
    s0 = n_short; l0 = n_long; d0 = n_dbl; q0 = rep_q.size();
    strobe_at(cyc + 5, 1, 0, p);
    wait_until(p + 99);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_busy_in_reset", busy, 0);
    check("t5_short_in_reset", short_press, 0);
    rst = 1'b0;
    strobe_at(cyc + 20, 0, 1, r);
    wait_until(r + 2200);
    check("t5_no_pulses", (n_short - s0) + (n_long - l0) + (n_dbl - d0) + (rep_q.size() - q0), 0);
    check("t5_busy_after", busy, 0);

    // Simultaneous strobes from IDLE are ignored.
    s0 = n_short; l0 = n_long; d0 = n_dbl;
    strobe_at(cyc + 5, 1, 1, p);
    wait_until(p + 2);
    check("t6_busy", busy, 0);
    wait_until(p + 2100);
    check("t6_no_pulses", (n_short - s0) + (n_long - l0) + (n_dbl - d0), 0);

    // Random strobes with occasional coincident strobes and reset pulses.
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk);
      rnd = $urandom_range(0, 999);
      btn_negedge = (rnd < 2) || (rnd == 4);
      btn_posedge = (rnd >= 2 && rnd < 4) || (rnd == 4);
      rst = ($urandom_range(0, 9999) == 0);
    end
    @(negedge clk);
    btn_negedge = 1'b0;
    btn_posedge = 1'b0;
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
